addsub_arbiter: RTL and testbench
=================================

Name: addsub_arbiter

Overview:
- Shares one signed DW-bit add/subtract accumulator datapath between two requesters.
- Each requester runs a job: a stream of operands, each one added to or subtracted from the accumulator, ended by a last flag. The block then returns the final value with sticky overflow status.
- Arbitration is round-robin per job. The grant is held for a whole job.
- Sits between command sources and the arithmetic core and replaces a free-running accumulate register.

Parameters:
- DW, 8: operand and accumulator width, two's complement.
- MAX_OPS, 255: maximum operands per job, 1..255. The job is force-terminated when it is reached.

Ports:
- Clk  input  1  clock, rising edge.
- Resetn  input  1  reset, synchronous, active-low.
- req0_valid  input  1  requester 0 operand valid.
- req0_ready  output  1  requester 0 operand accepted this cycle.
- req0_mode  input  1  0 = add, 1 = subtract (acc - data).
- req0_data  input  DW  requester 0 operand.
- req0_last  input  1  final operand of the job.
- req1_valid, req1_ready, req1_mode, req1_data, req1_last: same as requester 0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  result consumed.
- rsp_id  output  1  requester that owns the result.
- rsp_data  output  DW  final accumulator value.
- rsp_of  output  1  sticky signed overflow for the job.
- rsp_trunc  output  1  job ended by MAX_OPS without last.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (Resetn=0 at a rising edge):
  - state=IDLE, acc=0, of=0, trunc=0, opcnt=0, last_grant=1.
  - All outputs 0.
  - Reset mid-job abandons the job; no response is issued.
- FSM has three states: IDLE, RUN, RESP.
- IDLE:
  - req*_ready=0 and acc/of/trunc/opcnt are cleared.
  - If exactly one req*_valid is high, grant that requester.
  - If both are high, grant the requester that is not last_grant.
  - The grant is registered and the state moves to RUN on the next edge. No operand is consumed in IDLE.
  - Minimum latency: valid in cycle N, first handshake in cycle N+1.
- RUN:
  - Only the granted requester's ready=1; the other ready=0.
  - Handshake = valid & ready.
  - On a handshake, compute the DW+1-bit sign-extended result r = acc ± data.
    - acc <= r[DW-1:0] (wrap-around).
    - of <= of | (r outside [-2^(DW-1), 2^(DW-1)-1]). Subtracting -2^(DW-1) from acc >= 0 overflows.
    - opcnt increments.
  - Handshake with last=1 → RESP.
  - Handshake that makes opcnt==MAX_OPS while last=0 → RESP with trunc=1.
  - If last=1 on the MAX_OPS-th operand, trunc=0.
  - Granted valid low means wait; there is no timeout.
  - The other requester's valid is ignored and it stays pending.
- RESP:
  - rsp_valid=1; rsp_data=acc, rsp_of=of, rsp_trunc=trunc, rsp_id=grant.
  - All req*_ready=0.
  - Response fields stay stable while rsp_ready=0.
  - On rsp_valid & rsp_ready → IDLE and last_grant <= grant.
  - rsp_valid rises the cycle after the final handshake.
- Back-to-back: a new job's first operand is accepted no earlier than 2 cycles after the response handshake (IDLE, then RUN).
- busy=1 in RUN and RESP.

Optional Feature:
- Macro ADDSUB_ARBITER_SAT_EN.
- Defined: on overflow, acc saturates to 2^(DW-1)-1 (positive overflow) or -2^(DW-1) (negative overflow). Sticky of is still set.
- Undefined: wrap-around as above.
- Port list and timing are identical in both builds.

Test Plan:
- After reset, req0: add 10, then subtract 20 with last → rsp_id=0, rsp_data=0xF6, rsp_of=0, rsp_trunc=0; rsp_valid rises 1 cycle after the 2nd handshake.
- req0: add 100, then add 50 with last → rsp_data=0x96, rsp_of=1. With SAT_EN: rsp_data=0x7F, rsp_of=1.
- After reset, req0 and req1 valid in the same cycle, each with 1-operand jobs (add 5 / add 7) → req0 served first (rsp_data=0x05, rsp_id=0). Then req1 (0x07, id 1). Then a simultaneous request again grants req0.
- MAX_OPS=4, req1 streams 6 operands of add 1, last only on the 6th → response after 4th with rsp_data=0x04, rsp_trunc=1.
- rsp_ready held 0 for 3 cycles in RESP → rsp fields stable and req0_ready=req1_ready=0 throughout. Response handshakes on the 4th cycle, then IDLE.
- Resetn=0 after 2 of 3 operands → next cycle busy=0, rsp_valid=0. A new job then starts from acc=0.

Source files
------------

// File: rtl/addsub_arbiter_if.sv
// Request/response bundle for addsub_arbiter: two operand streams in, one result out.
interface addsub_arbiter_if #(
  parameter int DW = 8
);
  logic          req0_valid;
  logic          req0_ready;
  logic          req0_mode;
  logic [DW-1:0] req0_data;
  logic          req0_last;

  logic          req1_valid;
  logic          req1_ready;
  logic          req1_mode;
  logic [DW-1:0] req1_data;
  logic          req1_last;

  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [DW-1:0] rsp_data;
  logic          rsp_of;
  logic          rsp_trunc;

  // Command sources and result consumer.
  modport master (
    output req0_valid, req0_mode, req0_data, req0_last,
    input  req0_ready,
    output req1_valid, req1_mode, req1_data, req1_last,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_of, rsp_trunc,
    output rsp_ready
  );

  // The arbiter itself.
  modport slave (
    input  req0_valid, req0_mode, req0_data, req0_last,
    output req0_ready,
    input  req1_valid, req1_mode, req1_data, req1_last,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_of, rsp_trunc,
    input  rsp_ready
  );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin, job-granular sharing of one signed add/subtract accumulator between two requesters.
// Define ADDSUB_ARBITER_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module addsub_arbiter #(
  parameter int DW      = 8,
  parameter int MAX_OPS = 255
) (
  input  logic              Clk,
  input  logic              Resetn,
  addsub_arbiter_if.slave   bus,
  output logic              busy
);

  localparam int CW = $clog2(MAX_OPS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_OPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic          grant;
  logic          last_grant;
  logic [DW-1:0] acc;
  logic          of;
  logic          trunc;
  logic [CW-1:0] opcnt;

  // Operand path of whichever requester currently owns the datapath.
  logic          sel_valid;
  logic          sel_mode;
  logic [DW-1:0] sel_data;
  logic          sel_last;
  logic          hs;

  always_comb begin
    sel_valid = bus.req0_valid;
    sel_mode  = bus.req0_mode;
    sel_data  = bus.req0_data;
    sel_last  = bus.req0_last;
    if (grant) begin
      sel_valid = bus.req1_valid;
      sel_mode  = bus.req1_mode;
      sel_data  = bus.req1_data;
      sel_last  = bus.req1_last;
    end
  end

  assign hs = (state == RUN) && sel_valid;

  // One extra bit of headroom: the result overflowed when its two top bits disagree.
  logic [DW:0]   acc_x;
  logic [DW:0]   data_x;
  logic [DW:0]   sum;
  logic          ovf;
  logic [DW-1:0] acc_next;

  always_comb begin
    acc_x  = {acc[DW-1], acc};
    data_x = {sel_data[DW-1], sel_data};
    sum    = sel_mode ? (acc_x - data_x) : (acc_x + data_x);
    ovf    = sum[DW] ^ sum[DW-1];
`ifdef ADDSUB_ARBITER_SAT_EN
    if (ovf)
      acc_next = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      acc_next = sum[DW-1:0];
`else
    acc_next = sum[DW-1:0];
`endif
  end

  // NOTE: reset is synchronous here, so it lives inside the clocked branch rather than
  // in the sensitivity list; every state register uses non-blocking assignment so all
  // of them update together from the pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      acc        <= '0;
      of         <= 1'b0;
      trunc      <= 1'b0;
      opcnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          acc   <= '0;
          of    <= 1'b0;
          trunc <= 1'b0;
          opcnt <= '0;
          if (bus.req0_valid && bus.req1_valid) begin
            grant <= ~last_grant;
            state <= RUN;
          end else if (bus.req0_valid) begin
            grant <= 1'b0;
            state <= RUN;
          end else if (bus.req1_valid) begin
            grant <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          if (hs) begin
            acc   <= acc_next;
            of    <= of | ovf;
            opcnt <= opcnt + CW'(1);
            if (sel_last) begin
              state <= RESP;
            end else if (opcnt == LAST_CNT) begin
              // Operand budget exhausted without a last flag: force the job closed.
              trunc <= 1'b1;
              state <= RESP;
            end
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = (state == RUN) && !grant;
  assign bus.req1_ready = (state == RUN) && grant;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = grant;
  assign bus.rsp_data   = acc;
  assign bus.rsp_of     = of;
  assign bus.rsp_trunc  = trunc;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter (DW=8, MAX_OPS=4); honours ADDSUB_ARBITER_SAT_EN when defined.
module tb_addsub_arbiter;

`ifdef ADDSUB_ARBITER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic Clk;
  logic Resetn;
  logic busy;
  int   n_cmp;
  int   n_err;

  addsub_arbiter_if #(.DW(8)) bus ();

  addsub_arbiter #(.DW(8), .MAX_OPS(4)) dut (
    .Clk    (Clk),
    .Resetn (Resetn),
    .bus    (bus),
    .busy   (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic drive(input bit id, input bit v, input bit m, input logic [7:0] d, input bit l);
    if (id) begin
      bus.req1_valid = v; bus.req1_mode = m; bus.req1_data = d; bus.req1_last = l;
    end else begin
      bus.req0_valid = v; bus.req0_mode = m; bus.req0_data = d; bus.req0_last = l;
    end
  endtask

  task automatic apply_reset();
    Resetn = 1'b0;
    drive(0, 0, 0, 8'h00, 0);
    drive(1, 0, 0, 8'h00, 0);
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge Clk);
    Resetn = 1'b1;
  endtask

  // Presents one operand and returns on the negedge just after it is accepted.
  task automatic push(input bit id, input bit mode, input logic [7:0] d, input bit last);
    int n = 0;
    drive(id, 1, mode, d, last);
    while (!(id ? bus.req1_ready : bus.req0_ready) && n < 20) begin
      @(negedge Clk);
      n++;
    end
    n_cmp++;
    if (n >= 20) begin
      n_err++;
      $display("FAIL push_timeout: requester %0d saw no ready within 20 cycles, required ready", id);
    end
    @(negedge Clk);
    drive(id, 0, 0, 8'h00, 0);
  endtask

  task automatic ack_rsp();
    bus.rsp_ready = 1'b1;
    @(negedge Clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({busy, bus.rsp_valid, bus.req0_ready, bus.req1_ready, bus.rsp_id,
         bus.rsp_data, bus.rsp_of, bus.rsp_trunc} !== 13'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b rv=%b r0=%b r1=%b id=%b data=%h of=%b tr=%b, required all 0",
               busy, bus.rsp_valid, bus.req0_ready, bus.req1_ready, bus.rsp_id,
               bus.rsp_data, bus.rsp_of, bus.rsp_trunc);
    end
  endtask

  task automatic test_basic();
    drive(0, 1, 0, 8'd10, 0);
    n_cmp++;
    if (bus.req0_ready !== 1'b0) begin
      n_err++;
      $display("FAIL idle_ready: got req0_ready=%b, required 0", bus.req0_ready);
    end
    @(negedge Clk);
    n_cmp++;
    if ({busy, bus.req0_ready, bus.req1_ready} !== 3'b110) begin
      n_err++;
      $display("FAIL grant_latency: got busy/r0/r1=%b%b%b, required 110", busy, bus.req0_ready, bus.req1_ready);
    end
    push(0, 0, 8'd10, 0);
    push(0, 1, 8'd20, 1);
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_of, bus.rsp_trunc} !== {1'b1, 1'b0, 8'hF6, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL basic_rsp: got v=%b id=%b data=%h of=%b tr=%b, required v=1 id=0 data=f6 of=0 tr=0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_of, bus.rsp_trunc);
    end
    ack_rsp();
    n_cmp++;
    if ({busy, bus.rsp_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL basic_idle: got busy=%b rsp_valid=%b, required 0 0", busy, bus.rsp_valid);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp;
    // 100 + 50 = 150 overflows positive.
    push(0, 0, 8'd100, 0);
    push(0, 0, 8'd50, 1);
    exp = SAT ? 8'h7F : 8'h96;
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_of, bus.rsp_trunc} !== {1'b1, exp, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL ovf_pos: got v=%b data=%h of=%b tr=%b, required v=1 data=%h of=1 tr=0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_of, bus.rsp_trunc, exp);
    end
    ack_rsp();
    // 0 - (-128) = +128 overflows.
    push(1, 1, 8'h80, 1);
    exp = SAT ? 8'h7F : 8'h80;
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_of} !== {1'b1, 1'b1, exp, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_sub_min: got v=%b id=%b data=%h of=%b, required v=1 id=1 data=%h of=1",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_of, exp);
    end
    ack_rsp();
    // -128 - 1 = -129 overflows negative.
    push(0, 0, 8'h80, 0);
    push(0, 1, 8'h01, 1);
    exp = SAT ? 8'h80 : 8'h7F;
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_of} !== {1'b1, exp, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_neg: got v=%b data=%h of=%b, required v=1 data=%h of=1",
               bus.rsp_valid, bus.rsp_data, bus.rsp_of, exp);
    end
    ack_rsp();
    // Overflow on the 2nd operand must stay flagged after a clean 3rd operand.
    push(0, 0, 8'd100, 0);
    push(0, 0, 8'd50, 0);
    push(0, 1, 8'd10, 1);
    exp = SAT ? 8'h75 : 8'h8C;
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_of} !== {1'b1, exp, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_sticky: got v=%b data=%h of=%b, required v=1 data=%h of=1",
               bus.rsp_valid, bus.rsp_data, bus.rsp_of, exp);
    end
    ack_rsp();
  endtask

  task automatic test_arbitration();
    apply_reset();
    for (int round = 0; round < 2; round++) begin
      drive(0, 1, 0, 8'd5, 1);
      drive(1, 1, 0, 8'd7, 1);
      @(negedge Clk);
      n_cmp++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
        n_err++;
        $display("FAIL arb_first round %0d: got r0/r1=%b%b, required 10", round, bus.req0_ready, bus.req1_ready);
      end
      @(negedge Clk);
      drive(0, 0, 0, 8'h00, 0);
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req1_ready} !== {1'b1, 1'b0, 8'h05, 1'b0}) begin
        n_err++;
        $display("FAIL arb_rsp0 round %0d: got v=%b id=%b data=%h r1=%b, required v=1 id=0 data=05 r1=0",
                 round, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req1_ready);
      end
      ack_rsp();
      @(negedge Clk);
      n_cmp++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
        n_err++;
        $display("FAIL arb_second round %0d: got r0/r1=%b%b, required 01", round, bus.req0_ready, bus.req1_ready);
      end
      @(negedge Clk);
      drive(1, 0, 0, 8'h00, 0);
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b1, 8'h07}) begin
        n_err++;
        $display("FAIL arb_rsp1 round %0d: got v=%b id=%b data=%h, required v=1 id=1 data=07",
                 round, bus.rsp_valid, bus.rsp_id, bus.rsp_data);
      end
      ack_rsp();
    end
  endtask

  task automatic test_trunc();
    for (int i = 0; i < 4; i++) push(1, 0, 8'd1, 0);
    drive(1, 1, 0, 8'd1, 0);
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_of, bus.rsp_trunc, bus.req1_ready}
        !== {1'b1, 1'b1, 8'h04, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL trunc_rsp: got v=%b id=%b data=%h of=%b tr=%b r1=%b, required v=1 id=1 data=04 of=0 tr=1 r1=0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_of, bus.rsp_trunc, bus.req1_ready);
    end
    ack_rsp();
    // The leftover 5th and 6th operands form a fresh job.
    push(1, 0, 8'd1, 0);
    push(1, 0, 8'd1, 1);
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_trunc} !== {1'b1, 8'h02, 1'b0}) begin
      n_err++;
      $display("FAIL trunc_tail: got v=%b data=%h tr=%b, required v=1 data=02 tr=0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_trunc);
    end
    ack_rsp();
    // last on exactly the MAX_OPS-th operand is not a truncation.
    for (int i = 0; i < 3; i++) push(0, 0, 8'd1, 0);
    push(0, 0, 8'd1, 1);
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_trunc} !== {1'b1, 1'b0, 8'h04, 1'b0}) begin
      n_err++;
      $display("FAIL trunc_exact: got v=%b id=%b data=%h tr=%b, required v=1 id=0 data=04 tr=0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_trunc);
    end
    ack_rsp();
  endtask

  task automatic test_stall();
    push(0, 0, 8'd3, 1);
    drive(0, 1, 0, 8'd9, 0);
    drive(1, 1, 0, 8'd9, 0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_of, bus.rsp_trunc, bus.req0_ready, bus.req1_ready}
          !== {1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL stall cycle %0d: got v=%b id=%b data=%h of=%b tr=%b r0=%b r1=%b, required v=1 id=0 data=03 of=0 tr=0 r0=0 r1=0",
                 i, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_of, bus.rsp_trunc, bus.req0_ready, bus.req1_ready);
      end
      @(negedge Clk);
    end
    drive(0, 0, 0, 8'h00, 0);
    drive(1, 0, 0, 8'h00, 0);
    ack_rsp();
    n_cmp++;
    if ({busy, bus.rsp_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL stall_release: got busy=%b rsp_valid=%b, required 0 0", busy, bus.rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    push(0, 0, 8'd1, 0);
    push(0, 0, 8'd2, 0);
    Resetn = 1'b0;
    @(negedge Clk);
    Resetn = 1'b1;
    n_cmp++;
    if ({busy, bus.rsp_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_mid: got busy=%b rsp_valid=%b, required 0 0", busy, bus.rsp_valid);
    end
    push(0, 0, 8'd9, 1);
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_of} !== {1'b1, 1'b0, 8'h09, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid_restart: got v=%b id=%b data=%h of=%b, required v=1 id=0 data=09 of=0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_of);
    end
    ack_rsp();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_arbitration();
    test_trunc();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion");
    $fatal(1);
  end

endmodule
